// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the execute-stage buses.
//   - decode -> ex: in_valid/in_ready handshake plus the decoded instruction fields.
//   - ex <-> ALU: alu_op/alu_lhs/alu_rhs out, alu_res back in the same cycle.
//   - ex -> writeback: out_valid/out_ready handshake plus out_res/out_rd_idx/out_wen.
// Modports:
//   slave  - the execute stage itself.
//   master - its surroundings (decode, ALU and writeback together).
interface ex_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_op;
    logic            in_a_sel;
    logic            in_b_sel;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1_idx;
    logic [4:0]      in_rs2_idx;
    logic [4:0]      in_rd_idx;
    logic            in_wen;

    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_lhs;
    logic [XLEN-1:0] alu_rhs;
    logic [XLEN-1:0] alu_res;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [4:0]      out_rd_idx;
    logic            out_wen;

    modport slave (
        input  in_valid, in_alu_op, in_a_sel, in_b_sel, in_rs1_val, in_rs2_val, in_imm, in_pc,
               in_rs1_idx, in_rs2_idx, in_rd_idx, in_wen,
        output in_ready,
        output alu_op, alu_lhs, alu_rhs,
        input  alu_res,
        output out_valid, out_res, out_rd_idx, out_wen,
        input  out_ready
    );

    modport master (
        output in_valid, in_alu_op, in_a_sel, in_b_sel, in_rs1_val, in_rs2_val, in_imm, in_pc,
               in_rs1_idx, in_rs2_idx, in_rd_idx, in_wen,
        input  in_ready,
        input  alu_op, alu_lhs, alu_rhs,
        output alu_res,
        input  out_valid, out_res, out_rd_idx, out_wen,
        output out_ready
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the single-issue RV32I core.
//   Selects ALU operands (rs1/PC, rs2/imm), drives the external combinational ALU and
//   registers its result toward writeback through a main register M backed by a
//   one-entry skid register S, so that in_ready comes straight from a flop.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; empties M and S and zeroes the outputs
//   flush - drops M, S and any instruction offered in the same cycle
//   bus   - ex_stage_if.slave: decode handshake, ALU ports, writeback handshake
// Parameters:
//   XLEN  - data width; keep equal to REG_END_WORD+1 from defs.vh
// Configuration:
//   EX_FWD_EN - when defined, operands matching M's destination are forwarded from M.
module ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    ex_stage_if.slave bus
);

    logic            m_valid_q, m_valid_d;
    logic [XLEN-1:0] m_res_q, m_res_d;
    logic [4:0]      m_rd_q, m_rd_d;
    logic            m_wen_q, m_wen_d;

    logic            s_valid_q, s_valid_d;
    logic [XLEN-1:0] s_res_q, s_res_d;
    logic [4:0]      s_rd_q, s_rd_d;
    logic            s_wen_q, s_wen_d;

    logic            in_ready_q, in_ready_d;

    logic            accept;
    logic            fire;
    logic            entry_wen;
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
`ifdef EX_FWD_EN
    logic fwd_a;
    logic fwd_b;

    // Only M can forward: an accept requires S to be empty.
    assign fwd_a = m_valid_q && m_wen_q && (m_rd_q != 5'd0) &&
                   (m_rd_q == bus.in_rs1_idx) && !bus.in_a_sel;
    assign fwd_b = m_valid_q && m_wen_q && (m_rd_q != 5'd0) &&
                   (m_rd_q == bus.in_rs2_idx) && !bus.in_b_sel;

    always_comb begin
        lhs = bus.in_a_sel ? bus.in_pc : bus.in_rs1_val;
        rhs = bus.in_b_sel ? bus.in_imm : bus.in_rs2_val;
        if (fwd_a) begin
            lhs = m_res_q;
        end
        if (fwd_b) begin
            rhs = m_res_q;
        end
    end
`else
    logic unused_src_idx;

    assign unused_src_idx = ^{bus.in_rs1_idx, bus.in_rs2_idx};

    always_comb begin
        lhs = bus.in_a_sel ? bus.in_pc : bus.in_rs1_val;
        rhs = bus.in_b_sel ? bus.in_imm : bus.in_rs2_val;
    end
`endif

    assign bus.alu_op  = bus.in_alu_op;
    assign bus.alu_lhs = lhs;
    assign bus.alu_rhs = rhs;

    // ------------------------------------------------------------------
    // Handshakes and M/S next state
    // ------------------------------------------------------------------
    assign accept    = bus.in_valid && in_ready_q;
    assign fire      = m_valid_q && bus.out_ready;
    assign entry_wen = bus.in_wen && (bus.in_rd_idx != 5'd0);

    always_comb begin
        m_valid_d = m_valid_q;
        m_res_d   = m_res_q;
        m_rd_d    = m_rd_q;
        m_wen_d   = m_wen_q;
        s_valid_d = s_valid_q;
        s_res_d   = s_res_q;
        s_rd_d    = s_rd_q;
        s_wen_d   = s_wen_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            if (fire) begin
                if (s_valid_q) begin
                    m_valid_d = 1'b1;
                    m_res_d   = s_res_q;
                    m_rd_d    = s_rd_q;
                    m_wen_d   = s_wen_q;
                    s_valid_d = 1'b0;
                end else begin
                    m_valid_d = 1'b0;
                end
            end
            // accept implies S is empty, so the S->M move above never collides with this.
            if (accept) begin
                if (!m_valid_q || fire) begin
                    m_valid_d = 1'b1;
                    m_res_d   = bus.alu_res;
                    m_rd_d    = bus.in_rd_idx;
                    m_wen_d   = entry_wen;
                end else begin
                    s_valid_d = 1'b1;
                    s_res_d   = bus.alu_res;
                    s_rd_d    = bus.in_rd_idx;
                    s_wen_d   = entry_wen;
                end
            end
        end

        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_res_q    <= '0;
            m_rd_q     <= 5'd0;
            m_wen_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            s_res_q    <= '0;
            s_rd_q     <= 5'd0;
            s_wen_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            m_res_q    <= m_res_d;
            m_rd_q     <= m_rd_d;
            m_wen_q    <= m_wen_d;
            s_valid_q  <= s_valid_d;
            s_res_q    <= s_res_d;
            s_rd_q     <= s_rd_d;
            s_wen_q    <= s_wen_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = m_valid_q;
    assign bus.out_res    = m_res_q;
    assign bus.out_rd_idx = m_rd_q;
    assign bus.out_wen    = m_wen_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage.
//   Plays decode, the ALU and writeback. Expected outputs come from a queue model of
//   the instructions held by the stage (at most two) plus an architectural operand rule.
module tb_ex_stage;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } ent_t;

    logic clk;
    logic reset;
    logic flush;
    int   tests;
    int   fails;
    ent_t q[$];

    ex_stage_if #(.XLEN(XLEN)) bus ();

    ex_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return a ^ ~b;
        endcase
    endfunction

    // External combinational ALU.
    always_comb bus.alu_res = alu_fn(bus.alu_op, bus.alu_lhs, bus.alu_rhs);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic as, input logic bs,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] pc, input logic [4:0] i1, input logic [4:0] i2,
                         input logic [4:0] rd, input logic w);
        bus.in_valid   = v;
        bus.in_alu_op  = op;
        bus.in_a_sel   = as;
        bus.in_b_sel   = bs;
        bus.in_rs1_val = r1;
        bus.in_rs2_val = r2;
        bus.in_imm     = im;
        bus.in_pc      = pc;
        bus.in_rs1_idx = i1;
        bus.in_rs2_idx = i2;
        bus.in_rd_idx  = rd;
        bus.in_wen     = w;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 1'b0, 1'b0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // One clock: check outputs against the model, then advance the model over the edge.
    task automatic step(input logic ordy, input logic fl);
        bit          acc;
        bit          fr;
        ent_t        e;
        logic [31:0] el;
        logic [31:0] er;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("out_res", bus.out_res, q[0].res);
            check("out_rd_idx", {27'd0, bus.out_rd_idx}, {27'd0, q[0].rd});
            check("out_wen", {31'd0, bus.out_wen}, {31'd0, q[0].wen});
        end
        // Architectural operand value: the newest held result wins over a stale register read.
        el = bus.in_a_sel ? bus.in_pc : bus.in_rs1_val;
        er = bus.in_b_sel ? bus.in_imm : bus.in_rs2_val;
        if (FWD && q.size() > 0 && q[0].wen) begin
            if (!bus.in_a_sel && q[0].rd == bus.in_rs1_idx) el = q[0].res;
            if (!bus.in_b_sel && q[0].rd == bus.in_rs2_idx) er = q[0].res;
        end
        if (bus.in_valid) begin
            check("alu_op", {28'd0, bus.alu_op}, {28'd0, bus.in_alu_op});
            check("alu_lhs", bus.alu_lhs, el);
            check("alu_rhs", bus.alu_rhs, er);
        end
        acc   = bus.in_valid && q.size() < 2;
        fr    = q.size() > 0 && ordy;
        e.res = alu_fn(bus.in_alu_op, el, er);
        e.rd  = bus.in_rd_idx;
        e.wen = bus.in_wen && bus.in_rd_idx != 5'd0;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (fr) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_res", bus.out_res, 32'd0);
        check("rst_out_rd_idx", {27'd0, bus.out_rd_idx}, 32'd0);
        check("rst_out_wen", {31'd0, bus.out_wen}, 32'd0);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, OP_ADD, 1'b0, 1'b0, 32'd9, 32'd9, 0, 0, 5'd1, 5'd2, 5'd4, 1'b1);
        @(negedge clk);
        do_reset(2);

        // First accept after reset shows up one cycle later.
        drive(1'b1, OP_OR, 1'b0, 1'b0, 32'h0f, 32'hf0, 0, 0, 5'd8, 5'd9, 5'd0, 1'b0);
        step(1'b1, 1'b0);
        check("first_valid", {31'd0, bus.out_valid}, 32'd1);

        // Streaming: ADD 5+7 then SUB 10-3 with rd=0.
        drive(1'b1, OP_ADD, 1'b0, 1'b1, 32'd5, 0, 32'd7, 0, 5'd6, 5'd7, 5'd1, 1'b1);
        step(1'b1, 1'b0);
        check("stream_add", bus.out_res, 32'd12);
        drive(1'b1, OP_SUB, 1'b0, 1'b0, 32'd10, 32'd3, 0, 0, 5'd6, 5'd7, 5'd0, 1'b1);
        step(1'b1, 1'b0);
        check("stream_sub", bus.out_res, 32'd7);
        check("stream_wen_x0", {31'd0, bus.out_wen}, 32'd0);
        idle();
        step(1'b1, 1'b0);

        // Backpressure: three offered while writeback stalls.
        drive(1'b1, OP_ADD, 1'b0, 1'b1, 32'd100, 0, 32'd1, 0, 5'd10, 5'd11, 5'd12, 1'b1);
        step(1'b0, 1'b0);
        drive(1'b1, OP_ADD, 1'b0, 1'b1, 32'd200, 0, 32'd2, 0, 5'd10, 5'd11, 5'd13, 1'b1);
        step(1'b0, 1'b0);
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        drive(1'b1, OP_ADD, 1'b0, 1'b1, 32'd300, 0, 32'd3, 0, 5'd10, 5'd11, 5'd14, 1'b1);
        step(1'b0, 1'b0);
        check("bp_hold_m", bus.out_res, 32'd101);
        step(1'b1, 1'b0);
        check("bp_drain_s", bus.out_res, 32'd202);
        check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
        step(1'b1, 1'b0);
        check("bp_third", bus.out_res, 32'd303);
        idle();
        step(1'b1, 1'b0);

        // Flush with M and S full and a third instruction offered.
        drive(1'b1, OP_XOR, 1'b0, 1'b0, 32'h11, 32'h22, 0, 0, 5'd10, 5'd11, 5'd15, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        idle();
        repeat (3) step(1'b1, 1'b0);

        // Forwarding: ADD x3=1+2, then SLL x3 (stale 0) by 4.
        drive(1'b1, OP_ADD, 1'b0, 1'b0, 32'd1, 32'd2, 0, 0, 5'd1, 5'd2, 5'd3, 1'b1);
        step(1'b1, 1'b0);
        drive(1'b1, OP_SLL, 1'b0, 1'b1, 32'd0, 0, 32'd4, 0, 5'd3, 5'd0, 5'd5, 1'b1);
        step(1'b1, 1'b0);
        check("fwd_sll", bus.out_res, FWD ? 32'd48 : 32'd0);
        idle();
        step(1'b1, 1'b0);

        // SRA uses only the low five bits of rhs.
        drive(1'b1, OP_SRA, 1'b0, 1'b0, 32'h8000_0000, 32'h21, 0, 0, 5'd20, 5'd21, 5'd22, 1'b1);
        step(1'b1, 1'b0);
        check("sra", bus.out_res, 32'hC000_0000);

        // PC as lhs.
        drive(1'b1, OP_ADD, 1'b1, 1'b1, 32'd0, 0, 32'd4, 32'h100, 5'd20, 5'd21, 5'd23, 1'b1);
        step(1'b1, 1'b0);
        check("pc_plus_imm", bus.out_res, 32'h104);

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                drive(1'b1, OP_ADD, 1'b0, 1'b0, 1, 1, 0, 0, 5'd1, 5'd1, 5'd1, 1'b1);
                do_reset(1);
            end
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 11)), 1'($urandom),
                  1'($urandom), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the single-issue RV32I core, between decode and writeback. It accepts one decoded instruction per cycle over a valid/ready handshake and selects the ALU operands (rs1 or PC, rs2 or immediate). It drives the combinational ALU through its op/lhs/rhs/res ports and registers the result toward writeback, with a one-entry skid buffer so that `in_ready` is a registered signal.

## Interface
- `XLEN`, 32: data width; must equal `REG_END_WORD`+1 from `defs.vh`.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: discard all held instructions (branch redirect).
- `in_valid`  in  1: decode presents an instruction.
- `in_ready`  out  1: stage can accept; registered.
- `in_alu_op`  in  4: `ALU_OP_*` code.
- `in_a_sel`  in  1: 0 = `in_rs1_val`, 1 = `in_pc`.
- `in_b_sel`  in  1: 0 = `in_rs2_val`, 1 = `in_imm`.
- `in_rs1_val`, `in_rs2_val`, `in_imm`, `in_pc`  in  XLEN: operand sources.
- `in_rs1_idx`, `in_rs2_idx`, `in_rd_idx`  in  5: register indices.
- `in_wen`  in  1: instruction writes `rd`.
- `alu_op`  out  4: to ALU.
- `alu_lhs`, `alu_rhs`  out  XLEN: to ALU.
- `alu_res`  in  XLEN: from ALU (same cycle).
- `out_valid`  out  1: result available.
- `out_ready`  in  1: writeback accepts.
- `out_res`  out  XLEN: result.
- `out_rd_idx`  out  5: destination.
- `out_wen`  out  1: write enable; forced 0 when `out_rd_idx`==0.

## Operation
- Input handshake: accept when `in_valid && in_ready`. Output handshake: fire when `out_valid && out_ready`.
- The ALU ports are driven combinationally from the input side every cycle:
  - `alu_op`=`in_alu_op`.
  - `alu_lhs`=mux(`in_a_sel`).
  - `alu_rhs`=mux(`in_b_sel`).
  - Don't-care when `in_valid`=0.
- State: main register M {valid, res, rd, wen} drives `out_*`. Skid register S holds the same fields.
- On accept, the captured entry is {`alu_res`, `in_rd_idx`, `in_wen && in_rd_idx!=0`}:
  - M empty, or M firing this cycle → entry loads into M.
  - Otherwise → entry loads into S.
- On output fire with S valid → S moves to M and S empties.
- `in_ready` (next) = !S.valid (next), computed from the registered state.
- Accept and fire in the same cycle with S empty → M is replaced and throughput stays at 1/cycle.
- `flush` clears M.valid and S.valid.
  - It has priority over accept and over S→M transfer.
  - An instruction presented in the flush cycle is dropped.
- `reset` gives `out_valid`=0, `in_ready`=1, `out_res`=0, `out_rd_idx`=0, `out_wen`=0, S cleared. Reset mid-operation discards everything.
- Unknown `ALU_OP` codes pass through; the result is whatever the ALU returns.

## Timing
- Latency: accept in cycle N → `out_valid` in N+1.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- `out_ready` low for k cycles with continuous input: one extra instruction enters S, then `in_ready` drops the following cycle.
- When `out_ready` returns, S drains into M the next cycle, and `in_ready`=1 that same cycle.
- `in_ready` has no combinational path from `out_ready` or `in_valid`.
- `out_*` hold stable while `out_valid && !out_ready`.

## Configuration
- `EX_FWD_EN` defined: operand forwarding from M.
  - When M.valid && M.wen && M.rd==`in_rs1_idx` (and `in_a_sel`=0), `alu_lhs`=M.res.
  - Same rule for rhs with `in_rs2_idx`/`in_b_sel`.
  - S never forwards: an accept only occurs with S empty.
  - Index 0 never forwards.
- `EX_FWD_EN` undefined: operands come solely from the `in_*` values; the forwarding mux is absent.

## Test plan
- **Reset:** assert `reset` 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, all outputs 0; first accept after release yields `out_valid` one cycle later.
- **Streaming:** ADD rs1=5 imm=7 (b_sel=1) then SUB rs1=10 rs2=3, `out_ready`=1 → `out_res`=12 then 7 on consecutive cycles; the SUB with rd=0 gives `out_wen`=0.
- **Backpressure:** `out_ready`=0 for 3 cycles, 3 instructions offered → 2 held (M, S), `in_ready`=0 after the second, no loss or duplication, in-order drain once `out_ready`=1.
- **Flush:** flush while M and S are valid and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and none of the three results ever appear.
- **Forwarding (`EX_FWD_EN`):** ADD x3=1+2, then SLL rs1=x3 with stale `in_rs1_val`=0 and rhs=4 → `out_res`=48. With the macro undefined → `out_res`=0.
- **Shifts:** SRA lhs=0x80000000, rhs=0x21 → `out_res`=0xC0000000, because only the ALU's low 5 bits of rhs are used.
